dram_bank_responder: RTL and testbench

// - Cycle-approximate DRAM bank model. It is the responder side of the PIM/host

---
 rtl/dram_bank_responder.sv | 179 +++++++++++++++++
 tb/tb_dram_bank_responder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_bank_responder.sv
// Open-page DRAM bank model: one bank of rows, precharge/activate/write
// recovery timing, fixed-length read and write bursts.
module dram_bank_responder #(
   parameter int WIDTH                  = 64,
   parameter int BURST_LEN              = 4,
   parameter int ROW_WIDTH              = 512,
   parameter int NUM_ROWS               = 1024,
   parameter int ADDRESS_LEN            = 10,
   parameter int PRECHARGE_CYCLES       = 10,
   parameter int BANK_ACTIVATION_CYCLES = 20,
   parameter int DISCHARGE_CYCLES       = 10,
   localparam int NCOL  = ROW_WIDTH / (BURST_LEN * WIDTH),
   localparam int COL_W = (NCOL > 1) ? $clog2(NCOL) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [ADDRESS_LEN-1:0] req_row,
   input  logic [COL_W-1:0]       req_col,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [WIDTH-1:0]       wr_data,
   output logic                   rd_valid,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   rd_last,
   output logic                   row_open,
   output logic [ADDRESS_LEN-1:0] open_row,
   output logic                   busy
);

   localparam int WPR = ROW_WIDTH / WIDTH;
   localparam int IW  = $clog2(NUM_ROWS * WPR);
   localparam int BW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int CW  = 16;
   localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);

   typedef enum logic [2:0] {
      IDLE, PRECH, ACT, WBURST, RBURST, WREC
   } state_t;

   state_t state, next;

   logic [WIDTH-1:0]       mem [NUM_ROWS*WPR];
   logic                   lwrite;
   logic [ADDRESS_LEN-1:0] lrow;
   logic [COL_W-1:0]       lcol;
   logic [BW-1:0]          beat;
   logic [CW-1:0]          cnt;

   logic                   accept, take, miss, rd_load;
   logic [ADDRESS_LEN-1:0] ld_row;
   logic [COL_W-1:0]       ld_col;
   logic [BW-1:0]          ld_beat;

   function automatic logic [IW-1:0] widx(
      input logic [ADDRESS_LEN-1:0] r,
      input logic [COL_W-1:0]       c,
      input logic [BW-1:0]          b
   );
      int i;
      i = int'(r) * WPR + int'(c) * BURST_LEN + int'(b);
      return i[IW-1:0];
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next;
   end

   always_comb begin
      next      = state;
      req_ready = 1'b0;
      wr_ready  = 1'b0;
      rd_valid  = 1'b0;
      rd_last   = 1'b0;
      accept    = 1'b0;
      take      = 1'b0;
      miss      = 1'b0;
      rd_load   = 1'b0;
      ld_row    = lrow;
      ld_col    = lcol;
      ld_beat   = '0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept = 1'b1;
               if (row_open && open_row == req_row) begin
                  next    = req_write ? WBURST : RBURST;
                  rd_load = !req_write;
                  ld_row  = req_row;
                  ld_col  = req_col;
               end else if (!row_open) begin
                  next = ACT;
               end else begin
                  next = PRECH;
                  miss = 1'b1;
               end
            end
         end
         PRECH: begin
            if (cnt == CW'(PRECHARGE_CYCLES - 1)) next = ACT;
         end
         ACT: begin
            if (cnt == CW'(BANK_ACTIVATION_CYCLES - 1)) begin
               next    = lwrite ? WBURST : RBURST;
               rd_load = !lwrite;
            end
         end
         RBURST: begin
            rd_valid = 1'b1;
            if (beat == LAST) begin
               rd_last = 1'b1;
               next    = IDLE;
            end else begin
               rd_load = 1'b1;
               ld_beat = beat + 1'b1;
            end
         end
         WBURST: begin
            wr_ready = 1'b1;
            if (wr_valid) begin
               take = 1'b1;
               if (beat == LAST) next = WREC;
            end
         end
         WREC: begin
            if (cnt == CW'(DISCHARGE_CYCLES - 1)) next = IDLE;
         end
         default: next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lwrite   <= 1'b0;
         lrow     <= '0;
         lcol     <= '0;
         beat     <= '0;
         cnt      <= '0;
         row_open <= 1'b0;
         open_row <= '0;
         rd_data  <= '0;
      end else begin
         if (accept) begin
            lwrite <= req_write;
            lrow   <= req_row;
            lcol   <= req_col;
         end
         if (state != next) cnt <= '0;
         else               cnt <= cnt + 1'b1;
         if (state != next)                beat <= '0;
         else if (take || state == RBURST) beat <= beat + 1'b1;
         if (miss) row_open <= 1'b0;
         if (state == ACT && next != ACT) begin
            row_open <= 1'b1;
            open_row <= lrow;
         end
         // out-of-range rows read as zero
         if (rd_load) begin
            if (int'(ld_row) < NUM_ROWS)
               rd_data <= mem[widx(ld_row, ld_col, ld_beat)];
            else
               rd_data <= '0;
         end
      end
   end

   // array is deliberately outside reset so contents survive it
   always_ff @(posedge clk) begin
      if (take && int'(lrow) < NUM_ROWS)
         mem[widx(lrow, lcol, beat)] <= wr_data;
   end

endmodule

// File: tb/tb_dram_bank_responder.sv
// Bench for dram_bank_responder: directed timing scenarios plus random
// read/write traffic checked against a word-array model.
module tb_dram_bank_responder;

   localparam int PRE = 10;
   localparam int ACT = 20;
   localparam int DIS = 10;
   localparam int BL  = 4;
   localparam int WPR = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write;
   logic [9:0]  req_row;
   logic [0:0]  req_col;
   logic        wr_valid, wr_ready;
   logic [63:0] wr_data;
   logic        rd_valid, rd_last;
   logic [63:0] rd_data;
   logic        row_open;
   logic [9:0]  open_row;
   logic        busy;

   int          npass = 0;
   int          ntot  = 0;
   logic [63:0] mm [int];
   logic        mopen = 1'b0;
   int          mrow  = 0;
   logic [63:0] wbuf [4];
   int          rows [4] = '{3, 5, 7, 9};

   dram_bank_responder dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_row   (req_row),
      .req_col   (req_col),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_data   (wr_data),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .rd_last   (rd_last),
      .row_open  (row_open),
      .open_row  (open_row),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic int mlat(input int row);
      if (mopen && mrow == row) return 1;
      if (!mopen) return 1 + ACT;
      return 1 + PRE + ACT;
   endfunction

   function automatic int widx(input int row, input int col, input int k);
      return row * WPR + col * BL + k;
   endfunction

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!req_ready && n < 200) begin
         step();
         n++;
      end
      chk({tag, "_idle"}, 64'(req_ready), 64'(1));
   endtask

   task automatic fill_wbuf();
      for (int k = 0; k < 4; k++) wbuf[k] = {$urandom, $urandom};
   endtask

   task automatic do_read(input int row, input int col, input string tag);
      int   lat, elat;
      logic hit;
      elat = mlat(row);
      hit  = mopen && mrow == row;
      wait_ready(tag);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_row   = 10'(row);
      req_col   = 1'(col);
      step();
      req_valid = 1'b0;
      chk({tag, "_ready_low"}, 64'(req_ready), 64'(0));
      chk({tag, "_row_open_t1"}, 64'(row_open), 64'(hit));
      lat = 1;
      while (!rd_valid && lat < 100) begin
         step();
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(elat));
      for (int k = 0; k < 4; k++) begin
         chk({tag, "_valid"}, 64'(rd_valid), 64'(1));
         chk({tag, "_data"}, rd_data, mm[widx(row, col, k)]);
         chk({tag, "_last"}, 64'(rd_last), 64'(k == 3));
         step();
      end
      chk({tag, "_valid_end"}, 64'(rd_valid), 64'(0));
      mopen = 1'b1;
      mrow  = row;
      chk({tag, "_row_open"}, 64'(row_open), 64'(1));
      chk({tag, "_open_row"}, 64'(open_row), 64'(row));
   endtask

   task automatic do_write(input int row, input int col, input int gap,
                           input string tag);
      int k, cyc, g, n, ecyc;
      ecyc = mlat(row) - 1 + BL + gap;
      wait_ready(tag);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_row   = 10'(row);
      req_col   = 1'(col);
      step();
      req_valid = 1'b0;
      chk({tag, "_ready_low"}, 64'(req_ready), 64'(0));
      k   = 0;
      cyc = 0;
      g   = 0;
      while (k < 4 && cyc < 200) begin
         if (k == 2 && g < gap) begin
            wr_valid = 1'b0;
            g++;
         end else begin
            wr_valid = 1'b1;
            wr_data  = wbuf[k];
            if (wr_ready) k++;
         end
         step();
         cyc++;
      end
      chk({tag, "_burst_cycles"}, 64'(cyc), 64'(ecyc));
      wr_valid = 1'b1;
      wr_data  = 64'hDEAD_BEEF_DEAD_BEEF;
      chk({tag, "_wrec_wr_ready"}, 64'(wr_ready), 64'(0));
      chk({tag, "_wrec_busy"}, 64'(busy), 64'(1));
      n = 0;
      while (!req_ready && n < 50) begin
         step();
         n++;
      end
      wr_valid = 1'b0;
      chk({tag, "_wrec_cycles"}, 64'(n), 64'(DIS));
      for (int j = 0; j < 4; j++) mm[widx(row, col, j)] = wbuf[j];
      mopen = 1'b1;
      mrow  = row;
   endtask

   initial begin
      int acc, acc_cyc, nb;
      int bcyc [8] = '{1, 2, 3, 4, 6, 7, 8, 9};
      rst       = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_row   = '0;
      req_col   = '0;
      wr_valid  = 1'b0;
      wr_data   = '0;
      repeat (2) step();
      rst = 1'b0;

      foreach (rows[i]) begin
         for (int c = 0; c < 2; c++) begin
            fill_wbuf();
            do_write(rows[i], c, 0, "preload");
         end
      end

      #2 rst = 1'b1;
      #1;
      chk("rst_req_ready", 64'(req_ready), 64'(1));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_row_open", 64'(row_open), 64'(0));
      chk("rst_open_row", 64'(open_row), 64'(0));
      chk("rst_rd_valid", 64'(rd_valid), 64'(0));
      chk("rst_rd_data", rd_data, 64'(0));
      step();
      rst   = 1'b0;
      mopen = 1'b0;

      do_read(5, 0, "t1");

      wbuf = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
      do_write(5, 1, 0, "t2_wr");
      do_read(5, 1, "t2_rd");

      do_read(9, 1, "t3");

      fill_wbuf();
      do_write(9, 0, 3, "t4_wr");
      do_read(9, 0, "t4_rd");
      do_read(9, 1, "t4_nbr");

      wait_ready("t5");
      req_valid = 1'b1;
      req_write = 1'b0;
      req_row   = 10'd3;
      req_col   = 1'b0;
      step();
      req_valid = 1'b0;
      repeat (14) step();
      chk("t5_busy_in_act", 64'(busy), 64'(1));
      chk("t5_closed_in_act", 64'(row_open), 64'(0));
      #2 rst = 1'b1;
      #1;
      chk("t5_req_ready", 64'(req_ready), 64'(1));
      chk("t5_busy", 64'(busy), 64'(0));
      chk("t5_row_open", 64'(row_open), 64'(0));
      chk("t5_open_row", 64'(open_row), 64'(0));
      chk("t5_rd_valid", 64'(rd_valid), 64'(0));
      chk("t5_rd_last", 64'(rd_last), 64'(0));
      chk("t5_wr_ready", 64'(wr_ready), 64'(0));
      chk("t5_rd_data", rd_data, 64'(0));
      step();
      rst   = 1'b0;
      mopen = 1'b0;
      do_read(3, 0, "t5_reread");

      wait_ready("t6");
      req_valid = 1'b1;
      req_write = 1'b0;
      req_row   = 10'd3;
      req_col   = 1'b0;
      acc       = 0;
      acc_cyc   = -1;
      nb        = 0;
      for (int c = 0; c < 14; c++) begin
         if (rd_valid) begin
            if (nb < 8) begin
               chk("t6_beat_cycle", 64'(c), 64'(bcyc[nb]));
               chk("t6_data", rd_data, mm[widx(3, nb / 4, nb % 4)]);
               chk("t6_last", 64'(rd_last), 64'(nb % 4 == 3));
            end
            nb++;
         end
         if (req_ready && req_valid) begin
            acc++;
            if (acc == 2) acc_cyc = c;
         end
         step();
         if (acc == 1) req_col = 1'b1;
         if (acc == 2) req_valid = 1'b0;
      end
      chk("t6_accepts", 64'(acc), 64'(2));
      chk("t6_second_accept_cycle", 64'(acc_cyc), 64'(5));
      chk("t6_beats", 64'(nb), 64'(8));

      for (int i = 0; i < 12; i++) begin
         int r, c;
         r = rows[$urandom_range(0, 3)];
         c = int'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin
            fill_wbuf();
            do_write(r, c, int'($urandom_range(0, 2)), "rnd_wr");
         end else begin
            do_read(r, c, "rnd_rd");
         end
      end
      foreach (rows[i]) do_read(rows[i], 1, "final_rd");

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
